level_bar_peak_meter: RTL

- Display-side stage directly downstream of the section peak-to-peak buffer. Consumes its stream of width-bit peak-to-peak values.
- Converts each value to a half-octave (about 3 dB/step) log level.
- Runs a bar with instant attack and timed release, a peak marker with hold then decay, and a held clip flag.
- Emits one bar/peak/clip triple per accepted input over a valid/ready handshake to the LED/display driver.

---
 rtl/level_bar_peak_meter_pkg.sv | 17 +
 rtl/level_log2_encoder.sv | 30 +++
 rtl/level_bar_peak_meter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/level_bar_peak_meter_pkg.sv
// Shared types and helpers for the level bar/peak meter: FSM state encoding
// and the width function used to size level buses.
package level_bar_peak_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2,
    OUTPUT  = 2'd3
  } meter_state_t;

  // Levels run 0..2*width inclusive.
  function automatic int level_bits_of(input int width);
    return $clog2(2 * width + 1);
  endfunction

endpackage

// File: rtl/level_log2_encoder.sv
// Half-octave log encoder: level = 2*msb + (bit below msb) + 1, 0 for a zero
// input; clip flags a value whose top two bits are both set.
module level_log2_encoder
  import level_bar_peak_meter_pkg::*;
#(
  parameter int width = 16,
  localparam int level_bits = level_bits_of(width)
) (
  input  logic [width-1:0]      value,
  output logic [level_bits-1:0] level,
  output logic                  clip
);

  // below[i] is the bit just under position i (0 under the lsb).
  logic [width-1:0] below;
  assign below = {value[width-2:0], 1'b0};

  // NOTE: level gets a default before the loop so no path infers a latch.
  always_comb begin
    level = '0;
    for (int i = 0; i < width; i++) begin
      if (value[i]) begin
        level = level_bits'(2 * i + 1) + level_bits'(below[i]);
      end
    end
  end

  assign clip = value[width-1] & value[width-2];

endmodule

// File: rtl/level_bar_peak_meter.sv
// Bar/peak/clip display stage: log-encodes each accepted peak-to-peak value,
// runs bar release, peak hold/decay and clip hold, and emits one triple per input.
module level_bar_peak_meter
  import level_bar_peak_meter_pkg::*;
#(
  parameter int width      = 16,
  parameter int decay_div  = 4,
  parameter int hold_count = 8,
  localparam int level_bits = level_bits_of(width)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [width-1:0]      i_value,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [level_bits-1:0] o_bar,
  output logic [level_bits-1:0] o_peak,
  output logic                  o_clip
);

  localparam int dcnt_w = $clog2(decay_div) + 1;
  localparam int hcnt_w = $clog2(hold_count) + 1;

  meter_state_t state_q, state_n;

  logic [level_bits-1:0] enc_level, level_q;
  logic                  enc_clip, clip_in_q, clip_cond_q;
  logic                  o_valid_q;

  logic [level_bits-1:0] bar_q, bar_n, peak_q, peak_n, peak_dec;
  logic [dcnt_w-1:0]     bar_cnt_q, bar_cnt_n, peak_cnt_q, peak_cnt_n;
  logic [hcnt_w-1:0]     hold_q, hold_n, clip_cnt_q, clip_cnt_n;
  logic                  clip_q, clip_n;

  level_log2_encoder #(.width(width)) u_encoder (
    .value (i_value),
    .level (enc_level),
    .clip  (enc_clip)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (i_valid) state_n = CONVERT;
      CONVERT: state_n = UPDATE;
      UPDATE:  state_n = OUTPUT;
      OUTPUT:  if (o_valid_q && o_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bar, then peak against the new bar, then clip hold.
  always_comb begin
    bar_n      = bar_q;
    bar_cnt_n  = bar_cnt_q;
    peak_n     = peak_q;
    peak_cnt_n = peak_cnt_q;
    hold_n     = hold_q;
    clip_n     = clip_q;
    clip_cnt_n = clip_cnt_q;
    peak_dec   = peak_q - level_bits'(1);

    if (level_q >= bar_q) begin
      bar_n     = level_q;
      bar_cnt_n = '0;
    end else if (bar_cnt_q == dcnt_w'(decay_div - 1)) begin
      bar_n     = bar_q - level_bits'(1);
      bar_cnt_n = '0;
    end else begin
      bar_cnt_n = bar_cnt_q + dcnt_w'(1);
    end

    if (level_q >= peak_q) begin
      peak_n     = level_q;
      hold_n     = hcnt_w'(hold_count);
      peak_cnt_n = '0;
    end else if (hold_q != '0) begin
      hold_n = hold_q - hcnt_w'(1);
    end else if (peak_cnt_q == dcnt_w'(decay_div - 1)) begin
      peak_n     = (peak_dec > bar_n) ? peak_dec : bar_n;
      peak_cnt_n = '0;
    end else begin
      peak_cnt_n = peak_cnt_q + dcnt_w'(1);
    end

    if (clip_cond_q) begin
      clip_n     = 1'b1;
      clip_cnt_n = hcnt_w'(hold_count);
    end else if (clip_cnt_q != '0) begin
      clip_cnt_n = clip_cnt_q - hcnt_w'(1);
      if (clip_cnt_n == '0) clip_n = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q     <= '0;
      clip_in_q   <= 1'b0;
      clip_cond_q <= 1'b0;
      bar_q       <= '0;
      bar_cnt_q   <= '0;
      peak_q      <= '0;
      peak_cnt_q  <= '0;
      hold_q      <= '0;
      clip_q      <= 1'b0;
      clip_cnt_q  <= '0;
      o_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            level_q   <= enc_level;
            clip_in_q <= enc_clip;
          end
        end
        CONVERT: clip_cond_q <= clip_in_q;
        UPDATE: begin
          bar_q      <= bar_n;
          bar_cnt_q  <= bar_cnt_n;
          peak_q     <= peak_n;
          peak_cnt_q <= peak_cnt_n;
          hold_q     <= hold_n;
          clip_q     <= clip_n;
          clip_cnt_q <= clip_cnt_n;
        end
        default: ;
      endcase
      // Valid rises one cycle into OUTPUT and falls after the handshake.
      o_valid_q <= (state_q == OUTPUT) && !(o_valid_q && o_ready);
    end
  end

  assign i_ready = (state_q == IDLE);
  assign o_valid = o_valid_q;
  assign o_bar   = bar_q;
  assign o_peak  = peak_q;
  assign o_clip  = clip_q;

endmodule
